// File: rtl/microwave_pkg.sv
`default_nettype none
// ============================================================================
// Package     : microwave_pkg
// Description : Shared types and constants for the MM:SS cook-time loader.
//               State encoding, a packed four-digit BCD time word, and the
//               BCD limits used by the loader and its decrement helper.
// Revision    : 1.0 - initial release
// ============================================================================
package microwave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_COUNT = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Digit order matches the display, most significant first.
  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } mmss_t;

  localparam logic [3:0] DIGIT_MAX     = 4'd9;
  localparam logic [3:0] SEC_TENS_WRAP = 4'd5;
  localparam logic [3:0] BCD_NINE      = 4'd9;
  localparam mmss_t      ZERO_TIME     = '0;

endpackage
`default_nettype wire

// File: rtl/mmss_time_loader_if.sv
`default_nettype none
// ============================================================================
// Interface   : mmss_time_loader_if
// Description : Keypad-encoder / control bus seen by the cook-time loader.
//               master : keypad encoder and buttons (drives D, loadn, pgt_1hz,
//                        startn, stopn; observes digits and status)
//               slave  : mmss_time_loader
// Revision    : 1.0 - initial release
// ============================================================================
interface mmss_time_loader_if;
  logic [3:0] D;
  logic       loadn;
  logic       pgt_1hz;
  logic       startn;
  logic       stopn;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       enablen;
  logic       cooking;
  logic       done;

  modport master (
    output D, loadn, pgt_1hz, startn, stopn,
    input  min_tens, min_ones, sec_tens, sec_ones, enablen, cooking, done
  );

  modport slave (
    input  D, loadn, pgt_1hz, startn, stopn,
    output min_tens, min_ones, sec_tens, sec_ones, enablen, cooking, done
  );
endinterface
`default_nettype wire

// File: rtl/mmss_decrement.sv
`default_nettype none
// ============================================================================
// Module      : mmss_decrement
// Description : Combinational one-second BCD decrement of an MM:SS word.
//               Seconds borrow from minutes by reloading SEC_TENS_WRAP:9, so
//               keyed seconds above 59 simply count down digit by digit.
// Ports       : cur  - present time
//               nxt  - time minus one second
//               zero - nxt is 00:00
// Revision    : 1.0 - initial release
// ============================================================================
module mmss_decrement #(
  parameter logic [3:0] SEC_TENS_WRAP = microwave_pkg::SEC_TENS_WRAP
) (
  input  microwave_pkg::mmss_t cur,
  output microwave_pkg::mmss_t nxt,
  output logic                 zero
);
  import microwave_pkg::*;

  always_comb begin
    nxt = cur;
    if (cur.sec_ones != 4'd0) begin
      nxt.sec_ones = cur.sec_ones - 4'd1;
    end else if (cur.sec_tens != 4'd0) begin
      nxt.sec_tens = cur.sec_tens - 4'd1;
      nxt.sec_ones = BCD_NINE;
    end else begin
      // Minutes borrow: seconds reload, then the same ones/tens borrow on minutes.
      nxt.sec_tens = SEC_TENS_WRAP;
      nxt.sec_ones = BCD_NINE;
      if (cur.min_ones != 4'd0) begin
        nxt.min_ones = cur.min_ones - 4'd1;
      end else begin
        nxt.min_ones = BCD_NINE;
        nxt.min_tens = cur.min_tens - 4'd1;
      end
    end
    zero = (nxt == ZERO_TIME);
  end
endmodule
`default_nettype wire

// File: rtl/mmss_time_loader.sv
`default_nettype none
// ============================================================================
// Module      : mmss_time_loader
// Description : Shifts keyed BCD digits into an MM:SS cook time, counts it
//               down once per pgt_1hz rise, and locks the keypad while timing.
// Ports       : clk     - system clock
//               clearn  - asynchronous active-low reset
//               bus     - slave side of mmss_time_loader_if (key code, strobes,
//                         buttons in; digits, enablen, cooking, done out)
// Revision    : 1.0 - initial release
// ============================================================================
module mmss_time_loader #(
  parameter logic [3:0] SEC_TENS_WRAP = microwave_pkg::SEC_TENS_WRAP,
  parameter logic [3:0] DIGIT_MAX     = microwave_pkg::DIGIT_MAX
) (
  input  logic                  clk,
  input  logic                  clearn,
  mmss_time_loader_if.slave     bus
);
  import microwave_pkg::*;

  state_t state;
  mmss_t  cook_time;
  mmss_t  shifted;
  mmss_t  dec_time;
  logic   dec_zero;
  logic   enablen_q, cooking_q, done_q;

  // Previous-sample registers reset to 1 so no event is seen right after reset.
  logic   load_prev, start_prev, stop_prev, pgt_prev;
  logic   load_ev, start_ev, stop_ev, tick_ev;
  logic   key_ok, time_nonzero;

  assign load_ev  = load_prev  & ~bus.loadn;
  assign start_ev = start_prev & ~bus.startn;
  assign stop_ev  = stop_prev  & ~bus.stopn;
  assign tick_ev  = ~pgt_prev  &  bus.pgt_1hz;

  assign key_ok       = (bus.D <= DIGIT_MAX);
  assign time_nonzero = (cook_time != ZERO_TIME);
  assign shifted      = {cook_time.min_ones, cook_time.sec_tens, cook_time.sec_ones, bus.D};

  mmss_decrement #(
    .SEC_TENS_WRAP (SEC_TENS_WRAP)
  ) u_dec (
    .cur  (cook_time),
    .nxt  (dec_time),
    .zero (dec_zero)
  );

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state      <= ST_IDLE;
      cook_time  <= ZERO_TIME;
      enablen_q  <= 1'b0;
      cooking_q  <= 1'b0;
      done_q     <= 1'b0;
      load_prev  <= 1'b1;
      start_prev <= 1'b1;
      stop_prev  <= 1'b1;
      pgt_prev   <= 1'b1;
    end else begin
      load_prev  <= bus.loadn;
      start_prev <= bus.startn;
      stop_prev  <= bus.stopn;
      pgt_prev   <= bus.pgt_1hz;

      case (state)
        ST_IDLE: begin
          if (load_ev && key_ok) begin
            cook_time <= shifted;
            state     <= ST_ENTRY;
          end
        end

        ST_ENTRY: begin
          if (stop_ev) begin
            cook_time <= ZERO_TIME;
            state     <= ST_IDLE;
          end else if (start_ev && time_nonzero) begin
            state     <= ST_COUNT;
            enablen_q <= 1'b1;
            cooking_q <= 1'b1;
          end else if (load_ev && key_ok) begin
            cook_time <= shifted;
          end
        end

        ST_COUNT: begin
          // Stop wins over a coincident tick; that tick is dropped.
          if (stop_ev) begin
            state     <= ST_PAUSE;
            cooking_q <= 1'b0;
          end else if (tick_ev) begin
            cook_time <= dec_time;
            if (dec_zero) begin
              state     <= ST_DONE;
              enablen_q <= 1'b0;
              cooking_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end

        ST_PAUSE: begin
          // Ticks are ignored here, including one coincident with start.
          if (stop_ev) begin
            cook_time <= ZERO_TIME;
            state     <= ST_IDLE;
            enablen_q <= 1'b0;
          end else if (start_ev) begin
            state     <= ST_COUNT;
            cooking_q <= 1'b1;
          end
        end

        ST_DONE: begin
          // The key that acknowledges completion is not loaded.
          if (load_ev || start_ev || stop_ev) begin
            cook_time <= ZERO_TIME;
            state     <= ST_IDLE;
            done_q    <= 1'b0;
          end
        end

        default: begin
          cook_time <= ZERO_TIME;
          state     <= ST_IDLE;
          enablen_q <= 1'b0;
          cooking_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.min_tens = cook_time.min_tens;
  assign bus.min_ones = cook_time.min_ones;
  assign bus.sec_tens = cook_time.sec_tens;
  assign bus.sec_ones = cook_time.sec_ones;
  assign bus.enablen  = enablen_q;
  assign bus.cooking  = cooking_q;
  assign bus.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mmss_time_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmss_time_loader
// Description : Self-checking bench for mmss_time_loader: a fixed vector
//               table, hand-written corner sequences, and random stimulus
//               compared with an arithmetic reference model of the cook timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmss_time_loader;

  logic clk = 1'b0;
  logic clearn;
  always #5 clk = ~clk;

  mmss_time_loader_if bus();

  mmss_time_loader dut (
    .clk    (clk),
    .clearn (clearn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Time is held as the four keyed digits read as a decimal number MMSS.
  localparam int M_IDLE = 0, M_ENTRY = 1, M_COUNT = 2, M_PAUSE = 3, M_DONE = 4;
  int   m_state;
  int   m_n;
  logic mp_load, mp_start, mp_stop, mp_pgt;

  function automatic logic [15:0] to_bcd(int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic model_reset();
    m_state  = M_IDLE;
    m_n      = 0;
    mp_load  = 1'b1;
    mp_start = 1'b1;
    mp_stop  = 1'b1;
    mp_pgt   = 1'b1;
  endtask

  task automatic model_step();
    bit ld, sa, sp, tk, kv;
    int mm, ss;
    ld = mp_load  && !bus.loadn;
    sa = mp_start && !bus.startn;
    sp = mp_stop  && !bus.stopn;
    tk = !mp_pgt  && bus.pgt_1hz;
    kv = ld && (int'(bus.D) <= 9);
    case (m_state)
      M_IDLE:  if (kv) begin m_n = (m_n * 10 + int'(bus.D)) % 10000; m_state = M_ENTRY; end
      M_ENTRY: begin
        if (sp) begin m_n = 0; m_state = M_IDLE; end
        else if (sa && m_n != 0) m_state = M_COUNT;
        else if (kv) m_n = (m_n * 10 + int'(bus.D)) % 10000;
      end
      M_COUNT: begin
        if (sp) m_state = M_PAUSE;
        else if (tk) begin
          mm = m_n / 100;
          ss = m_n % 100;
          if (ss > 0) ss = ss - 1;
          else begin ss = 59; mm = mm - 1; end
          m_n = mm * 100 + ss;
          if (m_n == 0) m_state = M_DONE;
        end
      end
      M_PAUSE: begin
        if (sp) begin m_n = 0; m_state = M_IDLE; end
        else if (sa) m_state = M_COUNT;
      end
      default: if (ld || sa || sp) begin m_n = 0; m_state = M_IDLE; end
    endcase
    mp_load  = bus.loadn;
    mp_start = bus.startn;
    mp_stop  = bus.stopn;
    mp_pgt   = bus.pgt_1hz;
  endtask

  // ---------------- comparisons ----------------
  function automatic logic [18:0] dut_word();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
            bus.enablen, bus.cooking, bus.done};
  endfunction

  task automatic compare(string name, logic [18:0] exp);
    logic [18:0] got;
    got = dut_word();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got time=%h en=%b cook=%b done=%b, expected time=%h en=%b cook=%b done=%b",
               name, got[18:3], got[2], got[1], got[0], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_model(string name);
    logic en, ck, dn;
    en = (m_state == M_COUNT) || (m_state == M_PAUSE);
    ck = (m_state == M_COUNT);
    dn = (m_state == M_DONE);
    compare(name, {to_bcd(m_n), en, ck, dn});
  endtask

  task automatic expect_now(string name, logic [15:0] t, logic en, logic ck, logic dn);
    compare(name, {t, en, ck, dn});
  endtask

  // One clock: model consumes the current inputs, DUT samples them on the edge.
  task automatic cyc(string name);
    model_step();
    @(posedge clk);
    #1;
    check_model(name);
  endtask

  task automatic press(logic [3:0] d, int hold);
    bus.D     = d;
    bus.loadn = 1'b0;
    repeat (hold) cyc("key_hold");
    bus.loadn = 1'b1;
    cyc("key_release");
  endtask

  task automatic press_start();
    bus.startn = 1'b0; cyc("start");
    bus.startn = 1'b1; cyc("start_release");
  endtask

  task automatic press_stop();
    bus.stopn = 1'b0; cyc("stop");
    bus.stopn = 1'b1; cyc("stop_release");
  endtask

  task automatic one_sec();
    bus.pgt_1hz = 1'b1; cyc("tick");
    bus.pgt_1hz = 1'b0; cyc("tick_low");
  endtask

  // Reset asserted between clock edges; outputs must clear with no edge.
  task automatic async_reset();
    #2 clearn = 1'b0;
    #1 expect_now("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    #2 clearn = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  d;
    logic        ld, sa, sp, tk;
    logic [15:0] t;
    logic        en, ck, dn;
  } vec_t;
  vec_t tv[19];

  initial begin
    tv[0]  = '{4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{4'h1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0013, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0013, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0013, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0013, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0013, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0130, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0130, 1'b1, 1'b1, 1'b0};
    tv[9]  = '{4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0129, 1'b1, 1'b1, 1'b0};
    tv[10] = '{4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0129, 1'b1, 1'b1, 1'b0};
    tv[11] = '{4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0128, 1'b1, 1'b1, 1'b0};
    tv[12] = '{4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0128, 1'b1, 1'b1, 1'b0};
    tv[13] = '{4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0128, 1'b1, 1'b0, 1'b0};
    tv[14] = '{4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0128, 1'b1, 1'b1, 1'b0};
    tv[15] = '{4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0128, 1'b1, 1'b0, 1'b0};
    tv[16] = '{4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0128, 1'b1, 1'b0, 1'b0};
    tv[17] = '{4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tv[18] = '{4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.D       = 4'h0;
    bus.loadn   = 1'b1;
    bus.startn  = 1'b1;
    bus.stopn   = 1'b1;
    bus.pgt_1hz = 1'b0;
    clearn      = 1'b0;
    model_reset();
    #2 expect_now("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
    #5 clearn = 1'b1;
    cyc("post_reset");

    // Table: entry, countdown, pause with coincident start/tick, stop to idle.
    for (int i = 0; i < 19; i++) begin
      bus.D       = tv[i].d;
      bus.loadn   = tv[i].ld;
      bus.startn  = tv[i].sa;
      bus.stopn   = tv[i].sp;
      bus.pgt_1hz = tv[i].tk;
      model_step();
      @(posedge clk);
      #1;
      expect_now($sformatf("vec%0d", i), tv[i].t, tv[i].en, tv[i].ck, tv[i].dn);
    end

    // Entry with long key holds, invalid key, countdown, async reset at 01:10.
    press(4'd1, 10); press(4'd3, 10); press(4'd0, 10);
    expect_now("entry_0130", 16'h0130, 1'b0, 1'b0, 1'b0);
    press(4'hF, 10);
    expect_now("entry_bad_key", 16'h0130, 1'b0, 1'b0, 1'b0);
    press_start();
    repeat (3) one_sec();
    expect_now("count_0127", 16'h0127, 1'b1, 1'b1, 1'b0);
    repeat (17) one_sec();
    expect_now("count_0110", 16'h0110, 1'b1, 1'b1, 1'b0);
    async_reset();
    cyc("after_async_reset");

    // Overflow entry and start with zero time.
    for (int k = 1; k <= 5; k++) press(4'(k), 2);
    expect_now("overflow_2345", 16'h2345, 1'b0, 1'b0, 1'b0);
    press_stop();
    press(4'd0, 1); press(4'd0, 1);
    press_start();
    expect_now("start_zero", 16'h0000, 1'b0, 1'b0, 1'b0);
    press(4'd6, 1);
    expect_now("still_entry", 16'h0006, 1'b0, 1'b0, 1'b0);
    press_stop();

    // Minutes borrow.
    press(4'd1, 1); press(4'd0, 1); press(4'd0, 1);
    press_start();
    one_sec();
    expect_now("borrow_0059", 16'h0059, 1'b1, 1'b1, 1'b0);
    press_stop(); press_stop();

    // Completion and acknowledge key.
    press(4'd2, 1);
    press_start();
    repeat (2) one_sec();
    expect_now("done", 16'h0000, 1'b0, 1'b0, 1'b1);
    press(4'd7, 1);
    expect_now("done_ack", 16'h0000, 1'b0, 1'b0, 1'b0);
    press(4'd4, 1);
    expect_now("idle_after_done", 16'h0004, 1'b0, 1'b0, 1'b0);
    press_stop();

    // Stop and tick in the same cycle.
    press(4'd4, 1); press(4'd5, 1);
    press_start();
    bus.stopn = 1'b0; bus.pgt_1hz = 1'b1; cyc("stop_tick");
    expect_now("pause_0045", 16'h0045, 1'b1, 1'b0, 1'b0);
    bus.stopn = 1'b1; bus.pgt_1hz = 1'b0; cyc("stop_tick_rel");
    press_start();
    expect_now("resume_0045", 16'h0045, 1'b1, 1'b1, 1'b0);
    press_stop();
    press_stop();
    expect_now("stop_twice", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Random stimulus against the model.
    async_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.loadn = ~bus.loadn;
        if (!bus.loadn) bus.D = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 9) == 0)  bus.startn  = ~bus.startn;
      if ($urandom_range(0, 19) == 0) bus.stopn   = ~bus.stopn;
      if ($urandom_range(0, 2) == 0)  bus.pgt_1hz = ~bus.pgt_1hz;
      cyc("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
